// File: rtl/uart_dbus_tx_bridge_if.sv
// Bundle of the host-UART, transceiver-handshake and status signals of the
// UART to D-bus transmit bridge. The bridge takes the master view (it offers
// bytes to the transceiver); the transceiver/host side takes the slave view.
interface uart_dbus_tx_bridge_if #(
  parameter int FIFO_AW = 4
);
  logic               i_uart_rx;
  logic               i_busy;
  logic               i_receiving;
  logic [7:0]         o_data;
  logic               o_enable;
  logic               o_rts;
  logic [FIFO_AW:0]   o_fifo_count;
  logic               o_overrun;
  logic               o_frame_err;

  modport master (
    input  i_uart_rx, i_busy, i_receiving,
    output o_data, o_enable, o_rts, o_fifo_count, o_overrun, o_frame_err
  );

  modport slave (
    output i_uart_rx, i_busy, i_receiving,
    input  o_data, o_enable, o_rts, o_fifo_count, o_overrun, o_frame_err
  );
endinterface

// File: rtl/uart_dbus_tx_bridge.sv
// UART to TI-link D-bus transmit bridge.
// Receives host UART bytes, queues them in a circular byte FIFO and offers
// them one at a time to the D-bus transceiver, holding each offer until the
// transceiver starts transmitting (busy while not receiving).
// Build option: define UART_PARITY_EN for 8E1 framing (default is 8N1).
module uart_dbus_tx_bridge #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_dbus_tx_bridge_if.master bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]      FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   RTS_MAX  = (FIFO_AW + 1)'(DEPTH - 2);

  localparam logic [2:0] R_IDLE   = 3'd0;
  localparam logic [2:0] R_START  = 3'd1;
  localparam logic [2:0] R_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] R_PARITY = 3'd3;
`endif
  localparam logic [2:0] R_STOP   = 3'd4;
  localparam logic [2:0] R_BREAK  = 3'd5;

  localparam logic [1:0] T_IDLE     = 2'd0;
  localparam logic [1:0] T_OFFER    = 2'd1;
  localparam logic [1:0] T_WAITDONE = 2'd2;

  // FIFO occupancy after one cycle of optional push and pop
  function automatic logic [FIFO_AW:0] level_next(input logic [FIFO_AW:0] lvl,
                                                  input logic push, input logic pop);
    case ({push, pop})
      2'b10:   level_next = lvl + 1'b1;
      2'b01:   level_next = lvl - 1'b1;
      default: level_next = lvl;
    endcase
  endfunction

  logic               rx_p0, rx_p1;
  logic [2:0]         rx_state;
  logic [CW-1:0]      clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         rx_shift;
  logic [7:0]         rx_byte_p2;
  logic               vld_p2;
  logic               overrun_r, frame_err_r;
`ifdef UART_PARITY_EN
  logic               par_err;
`endif
  logic               data_tick, stop_tick;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic               rts_r;
  logic               pop;

  logic [1:0]         tx_state;
  logic [7:0]         data_r;
  logic               enable_r;

  // Two-flop synchroniser for the asynchronous host line (idles high)
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.i_uart_rx;
      rx_p1 <= rx_p0;
    end
  end

  assign data_tick = (rx_state == R_DATA) && (clk_cnt == FULL_M1);
  assign stop_tick = (rx_state == R_STOP) && (clk_cnt == FULL_M1);

  // Receive framing: start qualification, bit sampling, stop/break handling
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_state    <= R_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      vld_p2      <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      vld_p2      <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!rx_p1) begin
            rx_state <= R_START;
            clk_cnt  <= '0;
            bit_idx  <= '0;
          end
        end
        R_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt  <= '0;
            rx_state <= rx_p1 ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= R_PARITY;
`else
              rx_state <= R_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        R_PARITY: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt  <= '0;
            par_err  <= rx_p1 ^ (^rx_shift);
            rx_state <= R_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        R_STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (!rx_p1) begin
              frame_err_r <= 1'b1;
              rx_state    <= R_BREAK;
`ifdef UART_PARITY_EN
            end else if (par_err) begin
              frame_err_r <= 1'b1;
              rx_state    <= R_IDLE;
`endif
            end else begin
              rx_state <= R_IDLE;
              if (count == LVL_FULL) overrun_r <= 1'b1;
              else                   vld_p2    <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_BREAK: begin
          if (rx_p1) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Receive datapath: LSB-first shift register and the byte handed to the FIFO
  always_ff @(posedge i_clock) begin
    if (data_tick) rx_shift   <= {rx_p1, rx_shift[7:1]};
    if (stop_tick) rx_byte_p2 <= rx_shift;
  end

  // FIFO storage write
  always_ff @(posedge i_clock) begin
    if (vld_p2) mem[wptr] <= rx_byte_p2;
  end

  assign pop       = (tx_state == T_OFFER) && bus.i_busy && !bus.i_receiving;
  assign count_nxt = level_next(count, vld_p2, pop);

  // FIFO pointers, occupancy and registered host flow control
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rts_r <= 1'b1;
    end else begin
      if (vld_p2) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      count <= count_nxt;
      rts_r <= (count_nxt <= RTS_MAX);
    end
  end

  // Transceiver handshake: offer head, pop only once transmission has started
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_state <= T_IDLE;
      data_r   <= '0;
      enable_r <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (count != '0) begin
            data_r   <= mem[rptr];
            enable_r <= 1'b1;
            tx_state <= T_OFFER;
          end
        end
        T_OFFER: begin
          if (pop) begin
            enable_r <= 1'b0;
            tx_state <= T_WAITDONE;
          end
        end
        T_WAITDONE: begin
          if (!bus.i_busy) tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  assign bus.o_data       = data_r;
  assign bus.o_enable     = enable_r;
  assign bus.o_rts        = rts_r;
  assign bus.o_fifo_count = count;
  assign bus.o_overrun    = overrun_r;
  assign bus.o_frame_err  = frame_err_r;

endmodule

// File: doc/uart_dbus_tx_bridge.md
Name: uart_dbus_tx_bridge

Overview:
- Upstream feeder for the TI-link D-bus transceiver.
- Receives 8N1 bytes from a host UART, buffers them in a byte FIFO, and offers them one at a time to the transceiver through its i_data/i_enable/o_busy handshake.
- Backs off while the transceiver is receiving from the calculator.
- Exposes host flow control and error pulses.

Parameters:
CLKS_PER_BIT, 104, i_clock cycles per UART bit (12 MHz / 115200); must be >= 8.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
i_clock  input  1  system clock, all logic rising-edge.
i_reset  input  1  asynchronous, active-high reset.
i_uart_rx  input  1  host UART serial line, idle high, asynchronous to i_clock.
i_busy  input  1  transceiver o_busy.
i_receiving  input  1  transceiver o_receiving.
o_data  output  8  byte offered to transceiver i_data.
o_enable  output  1  offer strobe to transceiver i_enable.
o_rts  output  1  high = host may send; low when fewer than 2 FIFO entries are free.
o_fifo_count  output  FIFO_AW+1  current FIFO occupancy.
o_overrun  output  1  one-cycle pulse: a byte was received while the FIFO was full and was dropped.
o_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte dropped.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except o_rts=1; FIFO emptied; both FSMs to idle. Reset mid-frame or mid-offer discards the byte in flight. o_enable drops immediately.
- Input sync: i_uart_rx passes through 2 flops, reset value 1. All RX decisions use the synchronised signal.
- RX FSM:
  - R_IDLE: on sync line = 0 -> R_START, bit counter cleared.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. 0 -> R_DATA; 1 -> R_IDLE (glitch rejected, nothing pushed).
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles. If 1: push byte, or pulse o_overrun if full; -> R_IDLE. If 0: pulse o_frame_err, no push -> R_BREAK.
  - R_BREAK: stay until sync line = 1, then -> R_IDLE. A held-low line produces exactly one o_frame_err.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers that wrap modulo depth; count is FIFO_AW+1 bits.
  - Push and pop in the same cycle always both succeed, including when full or empty-with-push. Count is unchanged when both occur.
  - o_rts is registered: 1 when count <= depth-2.
- TX handshake FSM:
  - T_IDLE: if count != 0 -> latch FIFO head into o_data, o_enable <= 1, -> T_OFFER.
  - T_OFFER: o_data and o_enable are held stable. When i_busy=1 && i_receiving=0 (transmission started): o_enable <= 0, pop head, -> T_WAITDONE. If i_busy=1 && i_receiving=1, keep offering; the transceiver takes the byte after its receive completes.
  - T_WAITDONE: when i_busy=0 -> T_IDLE.
  - Minimum gap between the end of one byte and the next o_enable is 1 cycle. The transceiver's 2-cycle enable-to-busy latency is absorbed in T_OFFER.
  - A byte is popped only after acceptance, so no byte is lost if the transceiver is held in receive.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: frame is 8E1. The RX FSM adds R_PARITY between R_DATA and R_STOP. A parity mismatch pulses o_frame_err in the stop-bit cycle and the byte is not pushed; a low stop bit still -> R_BREAK.
- Undefined: 8N1, no R_PARITY state, no parity logic.

Test Plan:
1. Send 0xA5 at CLKS_PER_BIT=104, model i_busy rising 2 cycles after o_enable and falling 400 cycles later -> o_data=0xA5 and o_enable=1 until i_busy=1; then one pop, o_fifo_count 1->0.
2. 3-cycle low pulse on an idle i_uart_rx -> no push, no error pulses, RX returns to R_IDLE.
3. Hold i_busy=0 (transceiver never accepts); send 17 bytes 0x00..0x10 with FIFO_AW=4 -> count saturates at 16, o_rts=0 at count 15, one o_overrun pulse for 0x10; releasing i_busy drains 0x00..0x0F in order.
4. Frame 0x3C with stop bit low, line held low for 5 bit times -> exactly one o_frame_err, no push; next valid byte 0x11 is received correctly.
5. Byte queued while i_busy=1 && i_receiving=1 for 1000 cycles -> o_enable stays 1, no pop; after i_busy falls then rises with i_receiving=0 -> pop.
6. Assert i_reset in T_OFFER and mid-frame -> o_enable=0 the same cycle, count=0, o_rts=1; a clean byte 0x5A after release is delivered.
